port_io_sequencer: RTL and testbench

PORT_IO_SEQUENCER -- requirements
Module: port_io_sequencer

---
 rtl/port_io_pkg.sv | 47 ++++
 rtl/port_io_arb.sv | 80 ++++++++
 rtl/port_io_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_port_io_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_io_pkg.sv
// -----------------------------------------------------------------------------
// port_io_pkg
// Shared definitions for the port I/O sequencer: operation encodings, slot
// numbering of the free-running bus schedule and the in-flight FSM states.
// Slot map for N ports: 0 idle, then per port p: 1+3p dir, 2+3p read,
// 3+3p write, and a final slot 3N+1 before wrapping to 0.
// -----------------------------------------------------------------------------
package port_io_pkg;

  typedef enum logic [1:0] {
    OP_DIR   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_ILL   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,  // nothing in flight, arbitration open
    ST_WAIT   = 2'b01,  // captured, waiting for the target slot to come round
    ST_SLOT   = 2'b10,  // target slot is on the bus this cycle
    ST_SAMPLE = 2'b11   // read only: slot after the read slot, bus_in sampled at its end
  } state_e;

  localparam int SLOT_W         = 4;
  localparam int SLOT_IDLE      = 0;
  localparam int SLOT_OFS_DIR   = 1;
  localparam int SLOT_OFS_READ  = 2;
  localparam int SLOT_OFS_WRITE = 3;

  // Index of the final slot before the counter wraps to idle.
  function automatic logic [SLOT_W-1:0] slot_last(input int num_ports);
    return SLOT_W'(3 * num_ports + 1);
  endfunction

  // Slot in which an operation on a given port is served.
  function automatic logic [SLOT_W-1:0] target_slot(input op_e op, input logic [1:0] port);
    int ofs;
    case (op)
      OP_DIR:   ofs = SLOT_OFS_DIR;
      OP_READ:  ofs = SLOT_OFS_READ;
      OP_WRITE: ofs = SLOT_OFS_WRITE;
      default:  ofs = SLOT_IDLE;
    endcase
    return SLOT_W'(3 * int'(port) + ofs);
  endfunction

endpackage

// File: rtl/port_io_arb.sv
// -----------------------------------------------------------------------------
// port_io_arb
// Request arbiter for the port I/O sequencer.
//   PORT_IO_SEQ_RR_EN defined   : round-robin, pointer moves to one past the
//                                 requester granted when adv is high.
//   PORT_IO_SEQ_RR_EN undefined : fixed priority, lowest index wins, no state.
// Ports: clk, rst_n, adv (round-robin build only) - clock, async active-low
//        reset, grant-taken strobe; req - request vector; grant - one-hot grant.
// -----------------------------------------------------------------------------
module port_io_arb #(
  parameter int NUM_REQ = 2
) (
`ifdef PORT_IO_SEQ_RR_EN
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

`ifdef PORT_IO_SEQ_RR_EN
  logic [1:0] ptr_r;
  logic [1:0] ptr_nxt_s;
  logic       found_s;

  // Round-robin pick: first pass from the pointer upwards, second pass wraps.
  always_comb begin
    grant     = '0;
    ptr_nxt_s = ptr_r;
    found_s   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_s && req[j] && (j >= int'(ptr_r))) begin
        grant[j]  = 1'b1;
        ptr_nxt_s = 2'((j + 1) % NUM_REQ);
        found_s   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_s && req[j]) begin
        grant[j]  = 1'b1;
        ptr_nxt_s = 2'((j + 1) % NUM_REQ);
        found_s   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer only moves when the sequencer actually takes the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 2'd0;
    end else if (adv) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  logic found_s;

  // Fixed priority: lowest asserted index wins.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_s && req[j]) begin
        grant[j] = 1'b1;
        found_s  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

endmodule

// File: rtl/port_io_sequencer.sv
// -----------------------------------------------------------------------------
// port_io_sequencer
// Serialises requester operations (set-direction, read, write) onto a shared
// 8-bit port bus driven by a free-running slot schedule. One operation is in
// flight at a time; direction and output values live in per-port shadows that
// are replayed on the bus in every dir/write slot.
// Build option: PORT_IO_SEQ_RR_EN selects round-robin arbitration (default is
// fixed priority, lowest requester index first).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/op/port/wdata  per-requester request, held until req_ready
//   req_ready, req_err  one-cycle completion pulse / error qualifier
//   req_rdata           read result, loaded on read completion
//   bus_out, bus_oe     shared bus drive value and enable
//   bus_in              shared bus sampled value
// -----------------------------------------------------------------------------
module port_io_sequencer
  import port_io_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_PORTS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [2*NUM_REQ-1:0] req_port,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   req_err,
  output logic [7:0]           req_rdata,
  output logic [7:0]           bus_out,
  output logic                 bus_oe,
  input  logic [7:0]           bus_in
);

  localparam logic [SLOT_W-1:0] LAST = slot_last(NUM_PORTS);

  logic [SLOT_W-1:0]  slot_r, slot_nxt_s, target_s;
  state_e             state_r;
  op_e                op_r;
  logic [1:0]         port_r;
  logic [7:0]         wdata_r;
  logic [NUM_REQ-1:0] id_r;
  logic               err_r;
  logic [7:0]         shadow_dir_r [NUM_PORTS];
  logic [7:0]         shadow_out_r [NUM_PORTS];
  logic [7:0]         dir_nxt_s    [NUM_PORTS];
  logic [7:0]         out_nxt_s    [NUM_PORTS];
  logic [NUM_REQ-1:0] grant_s, req_ready_r, req_err_r;
  logic [7:0]         req_rdata_r, bus_out_r, bus_out_nxt_s;
  logic               bus_oe_r, bus_oe_nxt_s, grant_en_s, hit_s, sel_err_s;
  logic [1:0]         sel_op_s, sel_port_s;
  logic [7:0]         sel_wdata_s;

  assign req_ready = req_ready_r;
  assign req_err   = req_err_r;
  assign req_rdata = req_rdata_r;
  assign bus_out   = bus_out_r;
  assign bus_oe    = bus_oe_r;

  assign grant_en_s = (state_r == ST_IDLE) && (req_valid != '0);
  assign slot_nxt_s = (slot_r == LAST) ? '0 : slot_r + 1'b1;
  assign target_s   = target_slot(op_r, port_r);
  // Looking at the next slot means a capture landing in the target slot
  // itself cannot hit, so it naturally waits a full period.
  assign hit_s      = (state_r == ST_WAIT) && !err_r && (slot_nxt_s == target_s);

  port_io_arb #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef PORT_IO_SEQ_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (grant_en_s),
`endif
    .req   (req_valid),
    .grant (grant_s)
  );

  // Mux the granted requester's fields (grant is one-hot, so AND-OR suffices).
  always_comb begin
    sel_op_s    = 2'b00;
    sel_port_s  = 2'b00;
    sel_wdata_s = 8'h00;
    for (int r = 0; r < NUM_REQ; r++) begin
      sel_op_s    = sel_op_s    | (req_op[2*r +: 2]    & {2{grant_s[r]}});
      sel_port_s  = sel_port_s  | (req_port[2*r +: 2]  & {2{grant_s[r]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[8*r +: 8] & {8{grant_s[r]}});
    end
    sel_err_s = (sel_op_s == OP_ILL) || (int'(sel_port_s) >= NUM_PORTS);
  end

  // Shadow next-state: update lands exactly as the target slot starts.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      dir_nxt_s[p] = (hit_s && (op_r == OP_DIR) && (int'(port_r) == p))
                   ? wdata_r : shadow_dir_r[p];
      out_nxt_s[p] = (hit_s && (op_r == OP_WRITE) && (int'(port_r) == p))
                   ? wdata_r : shadow_out_r[p];
    end
  end

  // Bus drive next-state, decoded from the upcoming slot so the registered
  // bus outputs line up with slot_r.
  always_comb begin
    bus_oe_nxt_s  = 1'b0;
    bus_out_nxt_s = 8'h00;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (slot_nxt_s == SLOT_W'(3 * p + SLOT_OFS_DIR)) begin
        bus_oe_nxt_s  = 1'b1;
        bus_out_nxt_s = dir_nxt_s[p];
      end else if (slot_nxt_s == SLOT_W'(3 * p + SLOT_OFS_WRITE)) begin
        bus_oe_nxt_s  = 1'b1;
        bus_out_nxt_s = out_nxt_s[p];
      end else begin
        bus_oe_nxt_s = bus_oe_nxt_s;
      end
    end
  end

  // Free-running slot counter and registered bus drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r    <= '0;
      bus_oe_r  <= 1'b0;
      bus_out_r <= 8'h00;
    end else begin
      slot_r    <= slot_nxt_s;
      bus_oe_r  <= bus_oe_nxt_s;
      bus_out_r <= bus_out_nxt_s;
    end
  end

  // Per-port direction and output shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        shadow_dir_r[p] <= 8'h00;
        shadow_out_r[p] <= 8'h00;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        shadow_dir_r[p] <= dir_nxt_s[p];
        shadow_out_r[p] <= out_nxt_s[p];
      end
    end
  end

  // In-flight operation FSM with registered completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_DIR;
      port_r      <= 2'b00;
      wdata_r     <= 8'h00;
      id_r        <= '0;
      err_r       <= 1'b0;
      req_ready_r <= '0;
      req_err_r   <= '0;
      req_rdata_r <= 8'h00;
    end else begin
      req_ready_r <= '0;
      req_err_r   <= '0;
      case (state_r)
        ST_IDLE: begin
          if (grant_en_s) begin
            op_r    <= op_e'(sel_op_s);
            port_r  <= sel_port_s;
            wdata_r <= sel_wdata_s;
            id_r    <= grant_s;
            err_r   <= sel_err_s;
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (err_r) begin
            req_ready_r <= id_r;
            req_err_r   <= id_r;
            state_r     <= ST_IDLE;
          end else if (hit_s) begin
            state_r <= ST_SLOT;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_SLOT: begin
          if (op_r == OP_READ) begin
            state_r <= ST_SAMPLE;
          end else begin
            req_ready_r <= id_r;
            state_r     <= ST_IDLE;
          end
        end
        ST_SAMPLE: begin
          req_rdata_r <= bus_in;
          req_ready_r <= id_r;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_io_sequencer.sv
// -----------------------------------------------------------------------------
// tb_port_io_sequencer
// Self-checking bench for port_io_sequencer (NUM_REQ=2, NUM_PORTS=3). The
// reference model works in absolute cycle numbers: slot = cycle mod period,
// completion = first later occurrence of the target slot plus fixed offsets,
// shadow values switch at that occurrence.
// -----------------------------------------------------------------------------
module tb_port_io_sequencer;

  localparam int NR     = 2;
  localparam int NP     = 3;
  localparam int PERIOD = 3 * NP + 2;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [2*NR-1:0] req_op;
  logic [2*NR-1:0] req_port;
  logic [8*NR-1:0] req_wdata;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_err;
  logic [7:0]      req_rdata;
  logic [7:0]      bus_out;
  logic            bus_oe;
  logic [7:0]      bus_in;

  port_io_sequencer #(.NUM_REQ(NR), .NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_port  (req_port),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .bus_in    (bus_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // cycles since reset release; slot = cyc % PERIOD
  int m_ptr   = 0;

  logic [7:0] m_dir [NP];
  logic [7:0] m_out [NP];
  logic [7:0] m_dir_old [NP];
  logic [7:0] m_out_old [NP];
  int         m_dir_eff [NP];
  int         m_out_eff [NP];

  int         tr_n;
  int         tr_cyc [64];
  logic       tr_oe  [64];
  logic [7:0] tr_out [64];
  int         obs_cyc;
  logic [NR-1:0] obs_rdy, obs_err;
  logic [7:0] obs_rdata;

  task automatic tick();
    @(posedge clk);
    if (rst_n) cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_dir[p] = 8'h00; m_out[p] = 8'h00; m_dir_old[p] = 8'h00; m_out_old[p] = 8'h00;
      m_dir_eff[p] = 0; m_out_eff[p] = 0;
    end
    m_ptr = 0;
    cyc = 0;
  endtask

  function automatic logic exp_oe(input int c);
    int s;
    s = c % PERIOD;
    return (s >= 1) && (s <= 3 * NP) && (((s - 1) % 3) != 1);
  endfunction

  function automatic logic [7:0] exp_bus(input int c);
    int s, p;
    s = c % PERIOD;
    if (s < 1 || s > 3 * NP) return 8'h00;
    p = (s - 1) / 3;
    if (((s - 1) % 3) == 0) return (c >= m_dir_eff[p]) ? m_dir[p] : m_dir_old[p];
    if (((s - 1) % 3) == 2) return (c >= m_out_eff[p]) ? m_out[p] : m_out_old[p];
    return 8'h00;
  endfunction

  // First cycle after capture (cycle g+1) whose slot is the op's target slot.
  function automatic int exp_target(input int g, input int op, input int p);
    int t, c;
    t = 1 + 3 * p + op;
    if (op == 2) t = 3 + 3 * p;
    c = g + 2;
    return c + ((t - (c % PERIOD) + PERIOD) % PERIOD);
  endfunction

  // Stimulus: present one request at cycle g, record bus trace until its ready.
  task automatic run_op(input int r, input int op, input int p, input logic [7:0] wd,
                        input bit drop, output int g);
    g = cyc;
    req_valid[r] = 1'b1;
    req_op[2*r +: 2] = 2'(op);
    req_port[2*r +: 2] = 2'(p);
    req_wdata[8*r +: 8] = wd;
    m_ptr = (r + 1) % NR;
    tr_n = 0; obs_cyc = -1; obs_rdy = '0; obs_err = '0; obs_rdata = 8'h00;
    for (int i = 0; i < 40; i++) begin
      tr_cyc[tr_n] = cyc; tr_oe[tr_n] = bus_oe; tr_out[tr_n] = bus_out; tr_n++;
      if (i > 0 && req_ready != '0) begin
        obs_cyc = cyc; obs_rdy = req_ready; obs_err = req_err; obs_rdata = req_rdata;
        req_valid[r] = 1'b0;
        break;
      end
      if (drop && i == 2) req_valid[r] = 1'b0;
      tick();
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic model_apply(input int op, input int p, input logic [7:0] wd, input int t);
    if (op == 0) begin
      m_dir_old[p] = m_dir[p]; m_dir[p] = wd; m_dir_eff[p] = t;
    end else if (op == 2) begin
      m_out_old[p] = m_out[p]; m_out[p] = wd; m_out_eff[p] = t;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_port = '0; req_wdata = '0; bus_in = 8'h00;
    repeat (2) tick();
    n_tests++;
    if ({req_ready, req_err, req_rdata, bus_oe, bus_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b err=%b rdata=%02h oe=%b out=%02h want all zero",
               req_ready, req_err, req_rdata, bus_oe, bus_out);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * PERIOD; i++) begin
      n_tests++;
      if (bus_oe !== exp_oe(cyc) || bus_out !== 8'h00 || req_ready !== '0) begin
        n_fail++;
        $display("FAIL idle_schedule cyc=%0d got oe=%b out=%02h rdy=%b want oe=%b out=00 rdy=0",
                 cyc, bus_oe, bus_out, req_ready, exp_oe(cyc));
      end
      tick();
    end
  endtask

  task automatic test_dir_write();
    int g, t;
    logic [7:0] wd [2];
    int op [2];
    wd[0] = 8'hF0; wd[1] = 8'hA5; op[0] = 0; op[1] = 2;
    for (int k = 0; k < 2; k++) begin
      run_op(0, op[k], 1, wd[k], 1'b0, g);
      t = exp_target(g, op[k], 1);
      model_apply(op[k], 1, wd[k], t);
      n_tests++;
      if (obs_cyc !== t + 1 || obs_rdy !== 2'b01 || obs_err !== 2'b00) begin
        n_fail++;
        $display("FAIL dir_write_%0d got cyc=%0d rdy=%b err=%b want cyc=%0d rdy=01 err=00",
                 k, obs_cyc, obs_rdy, obs_err, t + 1);
      end
      for (int i = 0; i < tr_n; i++) begin
        n_tests++;
        if (tr_oe[i] !== exp_oe(tr_cyc[i]) || tr_out[i] !== exp_bus(tr_cyc[i])) begin
          n_fail++;
          $display("FAIL dir_write_bus cyc=%0d got oe=%b out=%02h want oe=%b out=%02h",
                   tr_cyc[i], tr_oe[i], tr_out[i], exp_oe(tr_cyc[i]), exp_bus(tr_cyc[i]));
        end
      end
    end
  endtask

  task automatic test_read();
    int g, t;
    bus_in = 8'h3C;
    run_op(1, 1, 2, 8'h00, 1'b0, g);
    t = exp_target(g, 1, 2);
    n_tests++;
    if (obs_cyc !== t + 2 || obs_rdy !== 2'b10 || obs_err !== 2'b00 || obs_rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_port2 got cyc=%0d rdy=%b err=%b rdata=%02h want cyc=%0d rdy=10 err=00 rdata=3c",
               obs_cyc, obs_rdy, obs_err, obs_rdata, t + 2);
    end
  endtask

  task automatic test_error();
    int g;
    int rq [2], op [2], pt [2];
    rq[0] = 0; op[0] = 2; pt[0] = 3;   // port out of range
    rq[1] = 1; op[1] = 3; pt[1] = 0;   // illegal op
    for (int k = 0; k < 2; k++) begin
      run_op(rq[k], op[k], pt[k], 8'hEE, 1'b0, g);
      n_tests++;
      if (obs_cyc !== g + 2 || obs_rdy !== 2'(1 << rq[k]) || obs_err !== 2'(1 << rq[k])) begin
        n_fail++;
        $display("FAIL error_%0d got cyc=%0d rdy=%b err=%b want cyc=%0d rdy=err=%b",
                 k, obs_cyc, obs_rdy, obs_err, g + 2, 2'(1 << rq[k]));
      end
      for (int i = 0; i < tr_n; i++) begin
        n_tests++;
        if (tr_oe[i] !== exp_oe(tr_cyc[i]) || tr_out[i] !== exp_bus(tr_cyc[i])) begin
          n_fail++;
          $display("FAIL error_bus cyc=%0d got oe=%b out=%02h want oe=%b out=%02h",
                   tr_cyc[i], tr_oe[i], tr_out[i], exp_oe(tr_cyc[i]), exp_bus(tr_cyc[i]));
        end
      end
    end
  endtask

  task automatic test_random();
    int g, t, r, op, p, exp_c;
    bit err;
    logic [7:0] wd, bin;
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, NR - 1);
      op = $urandom_range(0, 3);
      p = $urandom_range(0, 3);
      wd = 8'($urandom);
      bin = 8'($urandom);
      bus_in = bin;
      run_op(r, op, p, wd, 1'($urandom_range(0, 1)), g);
      err = (op == 3) || (p >= NP);
      if (err) begin
        exp_c = g + 2;
      end else begin
        t = exp_target(g, op, p);
        exp_c = t + 1 + ((op == 1) ? 1 : 0);
        model_apply(op, p, wd, t);
      end
      n_tests++;
      if (obs_cyc !== exp_c || obs_rdy !== 2'(1 << r) || obs_err !== (err ? 2'(1 << r) : 2'b00)
          || (op == 1 && !err && obs_rdata !== bin)) begin
        n_fail++;
        $display("FAIL random_%0d r=%0d op=%0d p=%0d got cyc=%0d rdy=%b err=%b rdata=%02h want cyc=%0d err=%0d rdata=%02h",
                 k, r, op, p, obs_cyc, obs_rdy, obs_err, obs_rdata, exp_c, err, bin);
      end
      for (int i = 0; i < tr_n; i++) begin
        n_tests++;
        if (tr_oe[i] !== exp_oe(tr_cyc[i]) || tr_out[i] !== exp_bus(tr_cyc[i])) begin
          n_fail++;
          $display("FAIL random_bus cyc=%0d got oe=%b out=%02h want oe=%b out=%02h",
                   tr_cyc[i], tr_oe[i], tr_out[i], exp_oe(tr_cyc[i]), exp_bus(tr_cyc[i]));
        end
      end
    end
  endtask

  task automatic test_arbitration();
    int exp_r;
    bit seen;
    req_op = {2'b10, 2'b10}; req_port = {2'b00, 2'b00}; req_wdata = {8'h11, 8'h22};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef PORT_IO_SEQ_RR_EN
      exp_r = m_ptr;
      m_ptr = (exp_r + 1) % NR;
`else
      exp_r = 0;
`endif
      seen = 1'b0;
      for (int i = 0; i < 3 * PERIOD; i++) begin
        tick();
        if (req_ready != '0) begin
          seen = 1'b1;
          break;
        end
      end
      n_tests++;
      if (!seen || req_ready !== 2'(1 << exp_r) || req_err !== 2'b00) begin
        n_fail++;
        $display("FAIL arb_grant_%0d got rdy=%b err=%b seen=%0d want rdy=%b err=00",
                 k, req_ready, req_err, seen, 2'(1 << exp_r));
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    bus_in = 8'h5A;
    req_valid[1] = 1'b1; req_op[3:2] = 2'b01; req_port[3:2] = 2'b10;
    tick();
    req_valid = '0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, req_err, req_rdata, bus_oe, bus_out} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset_outputs got rdy=%b err=%b rdata=%02h oe=%b out=%02h want all zero",
               req_ready, req_err, req_rdata, bus_oe, bus_out);
    end
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * PERIOD; i++) begin
      n_tests++;
      if (bus_oe !== exp_oe(cyc) || bus_out !== 8'h00 || req_ready !== '0) begin
        n_fail++;
        $display("FAIL midop_after_reset cyc=%0d got oe=%b out=%02h rdy=%b want oe=%b out=00 rdy=0",
                 cyc, bus_oe, bus_out, req_ready, exp_oe(cyc));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_dir_write();
    test_read();
    test_error();
    test_random();
    test_arbitration();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
